// File: rtl/instr_mem_loader_pkg.sv
// Shared constants and types for the instruction memory / byte-serial program loader.
package instr_mem_loader_pkg;

  localparam int          BYTES_PER_INSTR = 4;
  localparam logic [31:0] NOP_WORD        = 32'h0000_0000;
  localparam logic [31:0] DEF_HALT_WORD   = 32'hFFFF_FFFF;

  typedef struct packed {
    logic       valid;
    logic [7:0] data;
  } load_byte_t;

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// Big-endian 8->32 assembler: collects four bytes and presents the full word with a one-cycle strobe.
module instr_mem_loader_byte_assembler
  import instr_mem_loader_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  load_byte_t  i_req,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [1:0]  cnt_q, cnt_d;
  // Only the first three bytes need storage; the fourth is taken straight from the input.
  logic [23:0] shift_q, shift_d;

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (i_clear) begin
      cnt_d   = '0;
      shift_d = '0;
    end else if (i_req.valid) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], i_req.data};
    end
  end

  assign o_word       = {shift_q, i_req.data};
  assign o_word_valid = i_req.valid & ~i_clear & (cnt_q == 2'd3);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/instr_mem_loader.sv
// IF-stage instruction memory with asynchronous fetch, plus a UART-fed byte loader
// that tracks the number of complete words, end-of-program and overflow.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int                    SIZE_ADDR_PC = 32,
  parameter int                    SIZE_INSTR   = 32,
  parameter int                    MEM_DEPTH    = 256,
  parameter logic [SIZE_INSTR-1:0] HALT_WORD    = DEF_HALT_WORD,
  localparam int                   ADDR_W       = $clog2(MEM_DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic                    i_load_en,
  input  logic                    i_load_valid,
  input  logic [7:0]              i_load_byte,
  input  logic                    i_load_clear,
  input  logic [SIZE_ADDR_PC-1:0] i_pc,
  output logic [SIZE_INSTR-1:0]   o_instr,
  output logic                    o_halt,
  output logic [ADDR_W:0]         o_words_loaded,
  output logic                    o_load_done,
  output logic                    o_load_overflow
);

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(MEM_DEPTH);

  logic [SIZE_INSTR-1:0] mem_q [MEM_DEPTH];
  logic [ADDR_W:0]       words_q, words_d;
  logic                  done_q, done_d;
  logic                  ovf_q, ovf_d;

  logic       full, offer, accept, word_valid, mem_we;
  logic [31:0] word;
  load_byte_t req;

  assign full   = (words_q == DEPTH_CNT);
  assign offer  = i_load_en & i_load_valid & ~i_load_clear;
  assign accept = offer & ~done_q;
  assign req    = '{valid: accept, data: i_load_byte};

  instr_mem_loader_byte_assembler u_asm (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_clear      (i_load_clear),
    .i_req        (req),
    .o_word       (word),
    .o_word_valid (word_valid)
  );

  always_comb begin
    words_d = words_q;
    done_d  = done_q;
    ovf_d   = ovf_q;
    if (i_load_clear) begin
      words_d = '0;
      done_d  = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      if (word_valid) begin
        words_d = words_q + 1'b1;
        if (word == HALT_WORD || words_d == DEPTH_CNT) done_d = 1'b1;
      end
      // Full always implies done, so a byte here is never accepted, only flagged.
      if (offer && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      words_q <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      words_q <= words_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // RAM contents survive reset; the word count masks stale entries on fetch.
  assign mem_we = word_valid & ~i_reset;

  always_ff @(posedge i_clk) begin
    if (mem_we) mem_q[words_q[ADDR_W-1:0]] <= word;
  end

  logic [ADDR_W-1:0]              idx;
  logic [SIZE_ADDR_PC-ADDR_W-3:0] pc_hi;
  logic [1:0]                     unused_pc_lsb;
  logic                           in_range;

  assign idx           = i_pc[ADDR_W+1:2];
  assign pc_hi         = i_pc[SIZE_ADDR_PC-1:ADDR_W+2];
  assign unused_pc_lsb = i_pc[1:0];
  assign in_range      = ({1'b0, idx} < words_q) && (pc_hi == '0);

  assign o_instr         = (!i_load_en && in_range) ? mem_q[idx] : SIZE_INSTR'(NOP_WORD);
  assign o_halt          = ~i_load_en & (o_instr == HALT_WORD);
  assign o_words_loaded  = words_q;
  assign o_load_done     = done_q;
  assign o_load_overflow = ovf_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: a queue/array model checked every cycle plus literal expectations.
module tb_instr_mem_loader;

  localparam int          DEPTH = 256;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_load_en = 1'b0;
  logic        i_load_valid = 1'b0;
  logic [7:0]  i_load_byte = '0;
  logic        i_load_clear = 1'b0;
  logic [31:0] i_pc = '0;
  logic [31:0] o_instr;
  logic        o_halt;
  logic [8:0]  o_words_loaded;
  logic        o_load_done;
  logic        o_load_overflow;

  always #5 i_clk = ~i_clk;

  instr_mem_loader dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_load_en       (i_load_en),
    .i_load_valid    (i_load_valid),
    .i_load_byte     (i_load_byte),
    .i_load_clear    (i_load_clear),
    .i_pc            (i_pc),
    .o_instr         (o_instr),
    .o_halt          (o_halt),
    .o_words_loaded  (o_words_loaded),
    .o_load_done     (o_load_done),
    .o_load_overflow (o_load_overflow)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit chk_en  = 0;

  logic [31:0] m_mem [DEPTH];
  int          m_words = 0;
  bit          m_done  = 0;
  bit          m_ovf   = 0;
  logic [7:0]  m_part [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] exp_instr(input logic le, input logic [31:0] pc);
    if (le) return 32'h0;
    if (pc >= 32'(DEPTH * 4)) return 32'h0;
    if (int'(pc >> 2) >= m_words) return 32'h0;
    return m_mem[pc >> 2];
  endfunction

  task automatic model_update();
    logic [31:0] w;
    if (i_reset || i_load_clear) begin
      m_words = 0; m_done = 0; m_ovf = 0; m_part.delete();
    end else if (i_load_en && i_load_valid) begin
      if (m_words == DEPTH) m_ovf = 1;
      else if (!m_done) begin
        m_part.push_back(i_load_byte);
        if (m_part.size() == 4) begin
          w = {m_part[0], m_part[1], m_part[2], m_part[3]};
          m_mem[m_words] = w;
          m_words++;
          m_part.delete();
          if (w == HALT || m_words == DEPTH) m_done = 1;
        end
      end
    end
  endtask

  always @(negedge i_clk) begin
    logic [31:0] e;
    if (chk_en) begin
      e = exp_instr(i_load_en, i_pc);
      chk("instr", o_instr, e);
      chk("halt", 32'(o_halt), 32'(!i_load_en && e == HALT));
      chk("words_loaded", 32'(o_words_loaded), 32'(m_words));
      chk("load_done", 32'(o_load_done), 32'(m_done));
      chk("overflow", 32'(o_load_overflow), 32'(m_ovf));
    end
  end

  task automatic tick();
    @(posedge i_clk);
    model_update();
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_load_en = 1'b1; i_load_valid = 1'b1; i_load_byte = b;
    tick();
    i_load_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic do_clear();
    i_load_clear = 1'b1;
    tick();
    i_load_clear = 1'b0;
  endtask

  task automatic fetch(input logic le, input logic [31:0] pc);
    i_load_en = le; i_pc = pc;
    #1;
  endtask

  initial begin
    tick(); tick();
    i_reset = 1'b0;
    chk_en  = 1'b1;
    #1;
    chk("rst_instr", o_instr, 32'h0);
    chk("rst_halt", 32'(o_halt), 32'h0);
    chk("rst_words", 32'(o_words_loaded), 32'h0);
    chk("rst_done", 32'(o_load_done), 32'h0);
    chk("rst_ovf", 32'(o_load_overflow), 32'h0);

    // 1: two big-endian words
    send_word(32'h0000_0020);
    send_word(32'h8C01_0004);
    fetch(1'b0, 32'd0); chk("t1_pc0", o_instr, 32'h0000_0020);
    fetch(1'b0, 32'd4); chk("t1_pc4", o_instr, 32'h8C01_0004);
    fetch(1'b0, 32'd6); chk("t1_pc6", o_instr, 32'h8C01_0004);
    fetch(1'b0, 32'd8); chk("t1_pc8", o_instr, 32'h0);
    chk("t1_words", 32'(o_words_loaded), 32'd2);
    tick();

    // 2: halt terminates loading
    do_clear();
    send_word(32'h0000_0001);
    send_word(32'h0000_0002);
    send_word(32'h0000_0003);
    for (int k = 0; k < 3; k++) send_byte(8'hFF);
    chk("t2_done_before", 32'(o_load_done), 32'h0);
    send_byte(8'hFF);
    chk("t2_done", 32'(o_load_done), 32'h1);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56);
    chk("t2_ovf", 32'(o_load_overflow), 32'h0);
    chk("t2_words", 32'(o_words_loaded), 32'd4);
    fetch(1'b0, 32'd12);
    chk("t2_halt", 32'(o_halt), 32'h1);
    chk("t2_instr", o_instr, 32'hFFFF_FFFF);
    tick();

    // 3: fill the whole memory, then overflow
    do_clear();
    for (int i = 0; i < DEPTH; i++) send_word(32'h1000_0000 | 32'(i));
    chk("t3_done", 32'(o_load_done), 32'h1);
    chk("t3_ovf_before", 32'(o_load_overflow), 32'h0);
    send_byte(8'h99);
    chk("t3_ovf", 32'(o_load_overflow), 32'h1);
    chk("t3_words", 32'(o_words_loaded), 32'd256);
    fetch(1'b0, 32'd0);    chk("t3_mem0", o_instr, 32'h1000_0000);
    fetch(1'b0, 32'd1020); chk("t3_mem255", o_instr, 32'h1000_00FF);
    fetch(1'b0, 32'd1024); chk("t3_oob", o_instr, 32'h0);
    tick();

    // 4: clear wins over a simultaneous byte
    do_clear();
    chk("t4_cleared", 32'(o_words_loaded), 32'd0);
    send_byte(8'h77); send_byte(8'h88);
    i_load_valid = 1'b1; i_load_byte = 8'h55; i_load_clear = 1'b1;
    tick();
    i_load_valid = 1'b0; i_load_clear = 1'b0;
    send_word(32'h1122_3344);
    fetch(1'b0, 32'd0);
    chk("t4_mem0", o_instr, 32'h1122_3344);
    chk("t4_words", 32'(o_words_loaded), 32'd1);
    tick();

    // 5: reset mid-word wipes counters and partial bytes
    do_clear();
    send_word(32'hDEAD_BEEF);
    send_word(32'h0123_4567);
    send_byte(8'hAA); send_byte(8'hBB);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    fetch(1'b0, 32'd0); chk("t5_pc0", o_instr, 32'h0);
    fetch(1'b0, 32'd4); chk("t5_pc4", o_instr, 32'h0);
    chk("t5_words", 32'(o_words_loaded), 32'd0);
    chk("t5_done", 32'(o_load_done), 32'h0);
    chk("t5_ovf", 32'(o_load_overflow), 32'h0);
    send_word(32'hCAFE_F00D);
    fetch(1'b0, 32'd0); chk("t5_reload", o_instr, 32'hCAFE_F00D);
    tick();

    // 6: load mode forces NOP; pause mid-word then resume
    fetch(1'b1, 32'd0);
    chk("t6_le_instr", o_instr, 32'h0);
    chk("t6_le_halt", 32'(o_halt), 32'h0);
    send_byte(8'hAB); send_byte(8'hCD);
    i_load_en = 1'b0; i_load_valid = 1'b1; i_load_byte = 8'hEE;
    tick(); tick();
    i_load_valid = 1'b0;
    send_byte(8'hEF); send_byte(8'h01);
    fetch(1'b0, 32'd4); chk("t6_resume", o_instr, 32'hABCD_EF01);
    send_word(HALT);
    fetch(1'b1, 32'd8);
    chk("t6_le_halt_word", 32'(o_halt), 32'h0);
    fetch(1'b0, 32'd8);
    chk("t6_halt", 32'(o_halt), 32'h1);
    fetch(1'b0, 32'h0000_1000);
    chk("t6_far_pc", o_instr, 32'h0);
    tick(); tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
